aclk_multi_alarm: RTL and testbench
===================================

# aclk_multi_alarm

Parametrised alarm engine for the 24-hour alarm clock, replacing the single alarm register and single compare with NUM_ALARMS independent alarm channels. It sits beside the time counter and the LCD driver:
- Time inputs come from the counter; new alarm digits come from the key buffer.
- Each channel has enable, snooze (bounded count) and auto-silence timeout.
- A display read port lets the LCD driver show any stored alarm.

## Interface
Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..16); IDX_W = max(1, clog2(NUM_ALARMS)) is a derived localparam.
- SNOOZE_MIN, 5, minutes a snoozed alarm stays silent (>=1).
- MAX_SNOOZES, 3, snoozes allowed per trigger (0 disables snooze).
- RING_TIMEOUT_MIN, 10, minutes of continuous ringing before auto-silence (>=1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- one_minute  in  1  single-cycle pulse; the time counter advances on the same edge.
- current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  in  4 each  current time, BCD.
- new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  in  4 each  alarm digits to load, BCD.
- load_new_alarm  in  1  single-cycle pulse; writes the new_alarm digits into channel alarm_sel.
- alarm_sel  in  IDX_W  target channel for the load.
- alarm_enable  in  NUM_ALARMS  level-sensitive per-channel arm mask.
- snooze_button, stop_button  in  1 each  single-cycle pulses, already debounced.
- view_sel  in  IDX_W  channel shown on the view port.
- view_ms_hr, view_ls_hr, view_ms_min, view_ls_min  out  4 each  stored alarm time of view_sel; combinational read.
- ringing  out  NUM_ALARMS  channel is in RINGING.
- snoozed  out  NUM_ALARMS  channel is in SNOOZED.
- alarm_sound  out  1  OR of ringing.

## Operation
Time matching:
- eval = one_minute delayed by one register (one_minute_q), so the comparison always sees the updated time.
- Channel i matches when all four stored digits equal the current_time digits.
- Digits load unchecked; an invalid BCD alarm never matches.

Per-channel FSM (IDLE, RINGING, SNOOZED):
- IDLE -> RINGING:
  - Condition: eval, alarm_enable[i] and match.
  - Clears ring_cnt and snooze_used.
- RINGING, in priority order:
  - stop_button -> IDLE.
  - alarm_enable[i]=0 -> IDLE.
  - snooze_button with snooze_used < MAX_SNOOZES -> SNOOZED; snooze_cnt := SNOOZE_MIN, snooze_used++.
  - snooze_button at the snooze limit is ignored.
  - eval -> ring_cnt++; on reaching RING_TIMEOUT_MIN -> IDLE.
- SNOOZED:
  - stop_button -> IDLE.
  - alarm_enable[i]=0 -> IDLE.
  - eval -> snooze_cnt--; on reaching 0 -> RINGING with ring_cnt := 0.
  - snooze_button has no effect.
- A match while RINGING or SNOOZED is ignored; there is no re-trigger.

Buttons:
- Both buttons act on all channels simultaneously.
- If both arrive in the same cycle, stop wins.

Alarm load:
- load_new_alarm writes channel alarm_sel and forces that channel to IDLE with its counters cleared.
- If a load and a trigger on the same channel land in the same cycle, the load wins and there is no ring.
- An alarm_sel >= NUM_ALARMS load is ignored.
- A view_sel >= NUM_ALARMS reads all zeros.

Counter widths:
- snooze_cnt: clog2(SNOOZE_MIN+1).
- ring_cnt: clog2(RING_TIMEOUT_MIN+1).
- snooze_used: clog2(MAX_SNOOZES+1), minimum 1.
- Counters saturate and never wrap.

## Timing
- Reset:
  - All alarm digits 0 (00:00); all channels IDLE; all counters 0; one_minute_q 0.
  - ringing, snoozed and alarm_sound are 0; view outputs show 0.
  - Reset taking effect mid-ring silences the channel immediately and asynchronously.
- Trigger: one_minute high in cycle T -> eval in T+1 -> ringing[i] and alarm_sound high from T+2.
- Buttons: snooze or stop in cycle T -> state updated and outputs changed from T+1.
- Load: load_new_alarm in T -> view port shows the new value from T+1 when view_sel matches.
- Snooze: first ring resumes exactly SNOOZE_MIN eval pulses after the snooze press.
- Timeout: alarm_sound drops at eval pulse RING_TIMEOUT_MIN after entering RINGING (+1 cycle).
- Enable: alarm_enable falling in T -> channel IDLE from T+1.
- All outputs except view_* come directly from registers.

## Structure
- Shared package aclk_pkg:
  - FSM state encodings (IDLE=2'd0, RINGING=2'd1, SNOOZED=2'd2).
  - BCD digit width constant (4).
- Sub-module aclk_alarm_channel:
  - One alarm register, compare, FSM and counters.
  - Instantiated NUM_ALARMS times in a generate loop.
- Top level holds one_minute_q, load decode, view mux and the alarm_sound OR.

## Test plan
- Load ch0 with 07:30, enable=4'b0001, time steps 07:29->07:30 -> ringing=4'b0001 two cycles after the one_minute pulse; stop -> 0 next cycle.
- ch1 at 12:00 ringing; snooze -> snoozed[1]=1; after 5 one_minute pulses -> rings again.
- With MAX_SNOOZES=3, the 4th snooze is ignored and the alarm keeps ringing.
- ch2 at 23:59 ringing, no buttons -> silent after 10 minutes (time 00:09).
- ch0 and ch3 both set to 06:00 -> ringing=4'b1001; a single stop clears both.
- Load ch0 in the same cycle as its eval match -> no ring, and view shows the new time.
- Async reset mid-ring -> alarm_sound=0 with no clock edge, and the view port reads 00:00.

Source files
------------

// File: rtl/aclk_pkg.sv
// ---------------------------------------------------------------------------
// aclk_pkg
// Shared definitions for the multi-alarm engine of the 24-hour alarm clock:
// BCD digit width, the packed HH:MM time type, per-channel FSM encodings and
// a BCD time validity helper.
// ---------------------------------------------------------------------------
package aclk_pkg;

  localparam int DIGIT_W = 4;

  // Channel FSM encodings. Bit 0 set means RINGING and bit 1 set means
  // SNOOZED, so the channel status outputs are taken straight from the state
  // register.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
  localparam logic [1:0] ST_SNOOZED = 2'd2;

  typedef struct packed {
    logic [DIGIT_W-1:0] ms_hr;
    logic [DIGIT_W-1:0] ls_hr;
    logic [DIGIT_W-1:0] ms_min;
    logic [DIGIT_W-1:0] ls_min;
  } bcd_time_t;

  // True when t is a legal 00:00..23:59 BCD time.
  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic hr_ok;
    hr_ok = ((t.ms_hr < 4'd2) && (t.ls_hr <= 4'd9)) ||
            ((t.ms_hr == 4'd2) && (t.ls_hr <= 4'd3));
    return hr_ok && (t.ms_min <= 4'd5) && (t.ls_min <= 4'd9);
  endfunction

endpackage

// File: rtl/aclk_multi_alarm_if.sv
// ---------------------------------------------------------------------------
// aclk_multi_alarm_if
// Bus between the alarm engine and its neighbours:
//   - alarm load port, driven by the key buffer (new_alarm_*, load_new_alarm,
//     alarm_sel),
//   - view port, used by the LCD driver (view_sel in, view_* out).
// master: key buffer / LCD side.  slave: alarm engine side.
// ---------------------------------------------------------------------------
interface aclk_multi_alarm_if #(
  parameter int NUM_ALARMS = 4
);
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic [aclk_pkg::DIGIT_W-1:0] new_alarm_ms_hr;
  logic [aclk_pkg::DIGIT_W-1:0] new_alarm_ls_hr;
  logic [aclk_pkg::DIGIT_W-1:0] new_alarm_ms_min;
  logic [aclk_pkg::DIGIT_W-1:0] new_alarm_ls_min;
  logic                         load_new_alarm;
  logic [IDX_W-1:0]             alarm_sel;

  logic [IDX_W-1:0]             view_sel;
  logic [aclk_pkg::DIGIT_W-1:0] view_ms_hr;
  logic [aclk_pkg::DIGIT_W-1:0] view_ls_hr;
  logic [aclk_pkg::DIGIT_W-1:0] view_ms_min;
  logic [aclk_pkg::DIGIT_W-1:0] view_ls_min;

  modport master (
    output new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    output load_new_alarm, alarm_sel, view_sel,
    input  view_ms_hr, view_ls_hr, view_ms_min, view_ls_min
  );

  modport slave (
    input  new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min,
    input  load_new_alarm, alarm_sel, view_sel,
    output view_ms_hr, view_ls_hr, view_ms_min, view_ls_min
  );

endinterface

// File: rtl/aclk_alarm_channel.sv
// ---------------------------------------------------------------------------
// aclk_alarm_channel
// One alarm channel: stored alarm time, compare against the current time,
// IDLE/RINGING/SNOOZED FSM with bounded snooze and ring auto-silence.
// Ports:
//   clock, reset           clock, async active-high reset
//   eval                   one_minute delayed one cycle (time already updated)
//   cur_time               current time, BCD
//   load, new_time         load strobe for this channel and the digits to store
//   enable                 level-sensitive arm
//   snooze_button          snooze pulse
//   stop_button            stop pulse
//   alarm_time             stored alarm time
//   ringing, snoozed       channel status, straight from the state register
// ---------------------------------------------------------------------------
module aclk_alarm_channel
  import aclk_pkg::*;
#(
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZES      = 3,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      eval,
  input  bcd_time_t cur_time,
  input  logic      load,
  input  bcd_time_t new_time,
  input  logic      enable,
  input  logic      snooze_button,
  input  logic      stop_button,
  output bcd_time_t alarm_time,
  output logic      ringing,
  output logic      snoozed
);

  localparam int SNZ_W  = $clog2(SNOOZE_MIN + 1);
  localparam int RING_W = $clog2(RING_TIMEOUT_MIN + 1);
  localparam int USED_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

  logic [1:0]        st_q;
  bcd_time_t         alarm_q;
  logic [SNZ_W-1:0]  snooze_cnt_q;
  logic [RING_W-1:0] ring_cnt_q;
  logic [USED_W-1:0] snooze_used_q;

  logic match;
  logic snooze_ok;
  logic ring_last;
  logic ring_sat;

  // An invalid stored time must never fire, whatever the counter presents.
  assign match     = bcd_time_valid(alarm_q) && (alarm_q == cur_time);
  assign snooze_ok = snooze_used_q < USED_W'(MAX_SNOOZES);
  // This eval is the one that brings ring_cnt to RING_TIMEOUT_MIN.
  assign ring_last = ring_cnt_q >= RING_W'(RING_TIMEOUT_MIN - 1);
  assign ring_sat  = ring_cnt_q == RING_W'(RING_TIMEOUT_MIN);

  // NOTE: every register here, including the stored alarm digits, is in the
  // reset branch; the alarm time is user-visible state that must read 00:00
  // after reset, so it is not treated as reset-free storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q          <= ST_IDLE;
      alarm_q       <= '0;
      snooze_cnt_q  <= '0;
      ring_cnt_q    <= '0;
      snooze_used_q <= '0;
    end else if (load) begin
      // A load beats anything else this cycle, including a trigger.
      alarm_q       <= new_time;
      st_q          <= ST_IDLE;
      snooze_cnt_q  <= '0;
      ring_cnt_q    <= '0;
      snooze_used_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge counter values regardless of statement order.
      case (st_q)
        ST_IDLE: begin
          if (eval && enable && match) begin
            st_q          <= ST_RINGING;
            ring_cnt_q    <= '0;
            snooze_used_q <= '0;
          end
        end
        ST_RINGING: begin
          if (stop_button || !enable) begin
            st_q <= ST_IDLE;
          end else if (snooze_button && snooze_ok) begin
            st_q          <= ST_SNOOZED;
            snooze_cnt_q  <= SNZ_W'(SNOOZE_MIN);
            snooze_used_q <= snooze_used_q + 1'b1;
          end else if (eval) begin
            // A snooze at the limit falls through to here and is ignored.
            if (ring_last) st_q <= ST_IDLE;
            if (!ring_sat) ring_cnt_q <= ring_cnt_q + 1'b1;
          end
        end
        ST_SNOOZED: begin
          if (stop_button || !enable) begin
            st_q <= ST_IDLE;
          end else if (eval) begin
            if (snooze_cnt_q <= SNZ_W'(1)) begin
              st_q       <= ST_RINGING;
              ring_cnt_q <= '0;
            end
            if (snooze_cnt_q != '0) snooze_cnt_q <= snooze_cnt_q - 1'b1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign alarm_time = alarm_q;
  assign ringing    = st_q[0];
  assign snoozed    = st_q[1];

endmodule

// File: rtl/aclk_multi_alarm.sv
// ---------------------------------------------------------------------------
// aclk_multi_alarm
// NUM_ALARMS independent alarm channels for the 24-hour alarm clock.
// Ports:
//   clock, reset                  clock, async active-high reset
//   one_minute                    minute pulse (time counter advances on the
//                                 same edge)
//   current_time_*                current time digits, BCD
//   alarm_enable                  per-channel arm mask (level)
//   snooze_button, stop_button    debounced pulses, applied to all channels
//   ringing, snoozed              per-channel status, registered
//   alarm_sound                   OR of ringing
//   bus (slave)                   alarm load port and combinational view port
// ---------------------------------------------------------------------------
module aclk_multi_alarm
  import aclk_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZES      = 3,
  parameter int RING_TIMEOUT_MIN = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  one_minute,
  input  logic [DIGIT_W-1:0]    current_time_ms_hr,
  input  logic [DIGIT_W-1:0]    current_time_ls_hr,
  input  logic [DIGIT_W-1:0]    current_time_ms_min,
  input  logic [DIGIT_W-1:0]    current_time_ls_min,
  input  logic [NUM_ALARMS-1:0] alarm_enable,
  input  logic                  snooze_button,
  input  logic                  stop_button,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic [NUM_ALARMS-1:0] snoozed,
  output logic                  alarm_sound,
  aclk_multi_alarm_if.slave     bus
);

  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic      one_minute_q;
  bcd_time_t cur_time;
  bcd_time_t new_time;
  bcd_time_t view_time;
  bcd_time_t alarm_time [NUM_ALARMS];

  // Compare one cycle after the pulse so the counter has already advanced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) one_minute_q <= 1'b0;
    else       one_minute_q <= one_minute;
  end

  assign cur_time = '{current_time_ms_hr, current_time_ls_hr,
                      current_time_ms_min, current_time_ls_min};
  assign new_time = '{bus.new_alarm_ms_hr, bus.new_alarm_ls_hr,
                      bus.new_alarm_ms_min, bus.new_alarm_ls_min};

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    logic load_i;

    // An out-of-range alarm_sel matches no channel and the load is dropped.
    assign load_i = bus.load_new_alarm && (bus.alarm_sel == IDX_W'(i));

    aclk_alarm_channel #(
      .SNOOZE_MIN       (SNOOZE_MIN),
      .MAX_SNOOZES      (MAX_SNOOZES),
      .RING_TIMEOUT_MIN (RING_TIMEOUT_MIN)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .eval          (one_minute_q),
      .cur_time      (cur_time),
      .load          (load_i),
      .new_time      (new_time),
      .enable        (alarm_enable[i]),
      .snooze_button (snooze_button),
      .stop_button   (stop_button),
      .alarm_time    (alarm_time[i]),
      .ringing       (ringing[i]),
      .snoozed       (snoozed[i])
    );
  end

  // NOTE: view_time gets a default before the loop so no path leaves it
  // unassigned; an out-of-range view_sel then reads 00:00.
  always_comb begin
    view_time = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (bus.view_sel == IDX_W'(i)) view_time = alarm_time[i];
    end
  end

  assign bus.view_ms_hr  = view_time.ms_hr;
  assign bus.view_ls_hr  = view_time.ls_hr;
  assign bus.view_ms_min = view_time.ms_min;
  assign bus.view_ls_min = view_time.ls_min;

  assign alarm_sound = |ringing;

endmodule

// File: tb/tb_aclk_multi_alarm.sv
// ---------------------------------------------------------------------------
// tb_aclk_multi_alarm
// Directed scenarios followed by random traffic, all compared against a
// minute-level reference model of the alarm rules.
// ---------------------------------------------------------------------------
module tb_aclk_multi_alarm;

  localparam int N        = 4;
  localparam int SNZ_MIN  = 5;
  localparam int MAX_SNZ  = 3;
  localparam int RING_MAX = 10;

  logic         clock = 1'b0;
  logic         reset;
  logic         one_minute;
  logic [3:0]   current_time_ms_hr, current_time_ls_hr;
  logic [3:0]   current_time_ms_min, current_time_ls_min;
  logic [N-1:0] alarm_enable;
  logic         snooze_button, stop_button;
  logic [N-1:0] ringing, snoozed;
  logic         alarm_sound;

  aclk_multi_alarm_if #(.NUM_ALARMS(N)) bus ();

  aclk_multi_alarm #(
    .NUM_ALARMS       (N),
    .SNOOZE_MIN       (SNZ_MIN),
    .MAX_SNOOZES      (MAX_SNZ),
    .RING_TIMEOUT_MIN (RING_MAX)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .one_minute          (one_minute),
    .current_time_ms_hr  (current_time_ms_hr),
    .current_time_ls_hr  (current_time_ls_hr),
    .current_time_ms_min (current_time_ms_min),
    .current_time_ls_min (current_time_ls_min),
    .alarm_enable        (alarm_enable),
    .snooze_button       (snooze_button),
    .stop_button         (stop_button),
    .ringing             (ringing),
    .snoozed             (snoozed),
    .alarm_sound         (alarm_sound),
    .bus                 (bus)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef enum {M_OFF, M_RING, M_SNZ} mode_e;

  mode_e       m_mode  [N];
  logic [15:0] m_alarm [N];   // {ms_hr, ls_hr, ms_min, ls_min}
  int          m_left  [N];   // snooze minutes remaining
  int          m_rung  [N];   // minutes rung since (re)start
  int          m_used  [N];   // snoozes used this trigger
  logic        m_minute_seen; // minute pulse seen last cycle
  int          cur_min;       // minute of day, 0..1439

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int m);
    int h, mm;
    h  = m / 60;
    mm = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
  endfunction

  // Minute of day for a stored alarm, or -1 when it is not a legal time.
  function automatic int alarm_minutes(input logic [15:0] a);
    int h, mm;
    if (a[11:8] > 9 || a[3:0] > 9 || a[7:4] > 5) return -1;
    h  = int'(a[15:12]) * 10 + int'(a[11:8]);
    mm = int'(a[7:4]) * 10 + int'(a[3:0]);
    if (h > 23) return -1;
    return h * 60 + mm;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_mode[c]  = M_OFF;
      m_alarm[c] = '0;
      m_left[c]  = 0;
      m_rung[c]  = 0;
      m_used[c]  = 0;
    end
    m_minute_seen = 1'b0;
  endtask

  // Applies the alarm rules for the inputs present at one clock edge.
  task automatic model_step();
    logic        ev;
    logic [15:0] nt;
    ev = m_minute_seen;
    nt = {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min};
    for (int c = 0; c < N; c++) begin
      if (bus.load_new_alarm && int'(bus.alarm_sel) == c) begin
        m_alarm[c] = nt;
        m_mode[c]  = M_OFF;
        m_left[c]  = 0;
        m_rung[c]  = 0;
        m_used[c]  = 0;
      end else begin
        case (m_mode[c])
          M_OFF:
            if (ev && alarm_enable[c] && alarm_minutes(m_alarm[c]) == cur_min) begin
              m_mode[c] = M_RING;
              m_rung[c] = 0;
              m_used[c] = 0;
            end
          M_RING:
            if (stop_button || !alarm_enable[c]) m_mode[c] = M_OFF;
            else if (snooze_button && m_used[c] < MAX_SNZ) begin
              m_mode[c] = M_SNZ;
              m_left[c] = SNZ_MIN;
              m_used[c]++;
            end else if (ev) begin
              m_rung[c]++;
              if (m_rung[c] >= RING_MAX) m_mode[c] = M_OFF;
            end
          M_SNZ:
            if (stop_button || !alarm_enable[c]) m_mode[c] = M_OFF;
            else if (ev) begin
              m_left[c]--;
              if (m_left[c] == 0) begin
                m_mode[c] = M_RING;
                m_rung[c] = 0;
              end
            end
          default: m_mode[c] = M_OFF;
        endcase
      end
    end
    m_minute_seen = one_minute;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_time();
    {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min} = to_bcd(cur_min);
  endtask

  task automatic set_time(input int m);
    cur_min = m;
    drive_time();
  endtask

  task automatic compare_model();
    logic [N-1:0] er, es;
    for (int c = 0; c < N; c++) begin
      er[c] = (m_mode[c] == M_RING);
      es[c] = (m_mode[c] == M_SNZ);
    end
    check("ringing", 16'(ringing), 16'(er));
    check("snoozed", 16'(snoozed), 16'(es));
    check("alarm_sound", 16'(alarm_sound), 16'(|er));
    check("view", {bus.view_ms_hr, bus.view_ls_hr, bus.view_ms_min, bus.view_ls_min},
          m_alarm[bus.view_sel]);
  endtask

  // One clock: model follows the edge, time counter advances after it,
  // outputs are compared 1 time unit later and pulses are dropped.
  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    if (one_minute) begin
      cur_min = (cur_min + 1) % 1440;
      drive_time();
    end
    compare_model();
    one_minute         = 1'b0;
    bus.load_new_alarm = 1'b0;
    snooze_button      = 1'b0;
    stop_button        = 1'b0;
  endtask

  task automatic minute();
    one_minute = 1'b1;
    tick();
    tick();
  endtask

  task automatic load_alarm(input int ch, input logic [15:0] t);
    {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = t;
    bus.alarm_sel      = 2'(ch);
    bus.load_new_alarm = 1'b1;
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset              = 1'b1;
    one_minute         = 1'b0;
    alarm_enable       = '0;
    snooze_button      = 1'b0;
    stop_button        = 1'b0;
    bus.load_new_alarm = 1'b0;
    bus.alarm_sel      = '0;
    bus.view_sel       = '0;
    {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = '0;
    model_reset();
    set_time(0);

    #12;
    check("rst_ringing", 16'(ringing), 16'h0);
    check("rst_snoozed", 16'(snoozed), 16'h0);
    check("rst_sound", 16'(alarm_sound), 16'h0);
    check("rst_view", {bus.view_ms_hr, bus.view_ls_hr, bus.view_ms_min, bus.view_ls_min}, 16'h0000);
    #10 reset = 1'b0;

    // ch0 07:30: rings two cycles after the pulse, stop clears next cycle
    load_alarm(0, 16'h0730);
    check("load_view", {bus.view_ms_hr, bus.view_ls_hr, bus.view_ms_min, bus.view_ls_min}, 16'h0730);
    alarm_enable = 4'b0001;
    set_time(7 * 60 + 29);
    one_minute = 1'b1;
    tick();
    check("t1_not_yet", 16'(ringing), 16'h0);
    tick();
    check("t1_ring", 16'(ringing), 16'b0001);
    check("t1_sound", 16'(alarm_sound), 16'h1);
    stop_button = 1'b1;
    tick();
    check("t1_stop", 16'(ringing), 16'h0);

    // ch1 12:00: snooze cycles, 4th snooze ignored
    alarm_enable = 4'b0010;
    load_alarm(1, 16'h1200);
    set_time(11 * 60 + 59);
    minute();
    check("t2_ring", 16'(ringing), 16'b0010);
    snooze_button = 1'b1;
    tick();
    check("t2_snoozed", 16'(snoozed), 16'b0010);
    check("t2_quiet", 16'(ringing), 16'h0);
    for (int k = 0; k < SNZ_MIN - 1; k++) minute();
    check("t2_still_snz", 16'(snoozed), 16'b0010);
    minute();
    check("t2_resume", 16'(ringing), 16'b0010);
    for (int s = 0; s < 2; s++) begin
      snooze_button = 1'b1;
      tick();
      for (int k = 0; k < SNZ_MIN; k++) minute();
    end
    check("t2_resume3", 16'(ringing), 16'b0010);
    snooze_button = 1'b1;
    tick();
    check("t2_4th_ignored", 16'(ringing), 16'b0010);
    check("t2_4th_no_snz", 16'(snoozed), 16'h0);
    stop_button = 1'b1;
    tick();

    // ch2 23:59: auto-silence after RING_MAX minutes
    alarm_enable = 4'b0100;
    load_alarm(2, 16'h2359);
    set_time(23 * 60 + 58);
    minute();
    check("t3_ring", 16'(ringing), 16'b0100);
    for (int k = 0; k < RING_MAX - 1; k++) minute();
    check("t3_before_to", 16'(ringing), 16'b0100);
    minute();
    check("t3_timeout", 16'(alarm_sound), 16'h0);
    check("t3_time", {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min}, 16'h0009);

    // ch0 and ch3 at 06:00: one stop clears both
    alarm_enable = 4'b1001;
    load_alarm(0, 16'h0600);
    load_alarm(3, 16'h0600);
    set_time(5 * 60 + 59);
    minute();
    check("t4_both", 16'(ringing), 16'b1001);
    stop_button = 1'b1;
    tick();
    check("t4_stop", 16'(ringing), 16'h0);

    // load on the eval cycle of a matching alarm: load wins
    alarm_enable = 4'b0001;
    load_alarm(0, 16'h0800);
    set_time(7 * 60 + 59);
    one_minute = 1'b1;
    tick();
    {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = 16'h0800;
    bus.alarm_sel      = 2'd0;
    bus.load_new_alarm = 1'b1;
    tick();
    check("t5_no_ring", 16'(ringing), 16'h0);
    check("t5_view", {bus.view_ms_hr, bus.view_ls_hr, bus.view_ms_min, bus.view_ls_min}, 16'h0800);

    // async reset mid-ring
    set_time(7 * 60 + 59);
    minute();
    check("t6_ring", 16'(ringing), 16'b0001);
    #3 reset = 1'b1;
    #1;
    check("t6_rst_sound", 16'(alarm_sound), 16'h0);
    check("t6_rst_view", {bus.view_ms_hr, bus.view_ls_hr, bus.view_ms_min, bus.view_ls_min}, 16'h0000);
    model_reset();
    #2 reset = 1'b0;
    tick();

    // random traffic
    alarm_enable = 4'b1111;
    for (int n = 0; n < 2500; n++) begin
      one_minute    = ($urandom_range(0, 2) == 0);
      snooze_button = ($urandom_range(0, 9) == 0);
      stop_button   = ($urandom_range(0, 79) == 0);
      bus.view_sel  = 2'($urandom_range(0, N - 1));
      if ($urandom_range(0, 99) == 0) alarm_enable[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 7) == 0)
          {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} = 16'($urandom);
        else
          {bus.new_alarm_ms_hr, bus.new_alarm_ls_hr, bus.new_alarm_ms_min, bus.new_alarm_ls_min} =
            to_bcd((cur_min + int'($urandom_range(0, 3))) % 1440);
        bus.alarm_sel      = 2'($urandom_range(0, N - 1));
        bus.load_new_alarm = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
